// File: rtl/seq_alu.sv
// Handshaked sequential ALU: ADD/SUB/EPAR/BRANCH single-cycle, with an optional iterative multiplier.
// Optional feature macro: SEQ_ALU_MUL_EN (enables op 0110 shift-add multiply and the EXEC state).
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             format,
    input  logic             eq,
    input  logic [2:0]       ltgt,
    input  logic [WIDTH-1:0] res,
    input  logic [WIDTH-1:0] register,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             compres,
    output logic             busy
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_EPAR   = 4'b0101;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OP_MUL    = 4'b0110;
    localparam int         CNT_W     = $clog2(WIDTH);
`endif

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, state_next;
    logic   start;
    logic   is_mul;

    function automatic logic branch_taken(input logic eq_sel, input logic [2:0] sel,
                                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic taken;
        taken = 1'b0;
        case (sel)
            3'd0:    taken = eq_sel ? (a == b) : (a != b);
            3'd1:    taken = eq_sel ? (a <= b) : (a < b);
            3'd2:    taken = eq_sel ? (a >= b) : (a > b);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic [WIDTH-1:0] single_result(input logic [3:0] op_sel, input logic fmt,
                                                       input logic eq_sel,
                                                       input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        if (fmt) begin
            case (op_sel)
                OP_ADD:    r = eq_sel ? (a + b) : (a - b);
                OP_SUB:    r = a - b;
                OP_BRANCH: r = a;
                OP_EPAR:   r = {{(WIDTH-1){1'b0}}, ^a};
                default:   r = '0;
            endcase
        end
        return r;
    endfunction

    assign start     = in_valid && in_ready;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
    logic [CNT_W-1:0] cnt;
    logic             mul_last;

    assign is_mul   = format && (op == OP_MUL);
    assign busy     = (state == EXEC);
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign mul_last = (state == EXEC) && (cnt == CNT_W'(WIDTH - 1));

    // Shift-add: one multiplier bit per EXEC cycle, product truncated to WIDTH bits.
    always_ff @(posedge clock) begin
        if (start) begin
            mcand  <= res;
            mplier <= register;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == EXEC) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`else
    assign is_mul = 1'b0;
    assign busy   = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = is_mul ? EXEC : DONE;
`ifdef SEQ_ALU_MUL_EN
            EXEC: if (mul_last) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            out     <= '0;
            compres <= 1'b0;
        end else begin
            state <= state_next;
            if (start && !is_mul) begin
                out     <= single_result(op, format, eq, res, register);
                compres <= format && (op == OP_BRANCH) && branch_taken(eq, ltgt, res, register);
            end
`ifdef SEQ_ALU_MUL_EN
            if (mul_last) begin
                out     <= acc_next;
                compres <= 1'b0;
            end
`endif
        end
    end

endmodule
